rtc_bus_arbiter: RTL and testbench

Sequencer and arbiter for the RTC's multiplexed 8-bit address/data bus.
- Two requesters share the bus: the periodic register reader (time/date refresh) and the editor/initialiser (register writes).
- The block grants one requester at a time and runs one complete bus cycle: address phase, then data phase, then recovery gap.
- Sits between the top-level RTC state machine and the RTC pins; it replaces the per-FSM ad-hoc driving of control/AD.

---
 rtl/rtc_bus_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbiter.sv
// Arbiter/sequencer for the RTC multiplexed AD bus: address phase, data phase, recovery gap.
// Define RTC_RR_ARB_EN for round-robin arbitration; otherwise writes have fixed priority over reads.
module rtc_bus_arbiter #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 4,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_GAP   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       window,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic       rd_ack,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       rtc_cs_n,
    output logic       rtc_ad_n,
    output logic       rtc_wr_n,
    output logic       rtc_rd_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A_SU = 3'd1,
        A_PW = 3'd2,
        A_HD = 3'd3,
        D_SU = 3'd4,
        D_PW = 3'd5,
        D_HD = 3'd6,
        GAP  = 3'd7
    } state_t;

    localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
    localparam logic [3:0] LD_PULSE = 4'(T_PULSE - 1);
    localparam logic [3:0] LD_HOLD  = 4'(T_HOLD - 1);
    localparam logic [3:0] LD_GAP   = 4'(T_GAP - 1);

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [7:0] addr_r, data_r;
    logic       dir_wr_r;
    logic       grant_s, grant_wr_s;
    logic       cs_n_s, ad_n_s, wr_n_s, rd_n_s, ad_oe_s, busy_s;
    logic       wr_ack_s, rd_ack_s, capture_s;
    logic [7:0] ad_out_s;

`ifdef RTC_RR_ARB_EN
    logic last_grant_r;

    // Round-robin winner selection: contested grants alternate; 1 = write
    always_comb begin
        if (wr_req && rd_req) begin
            grant_wr_s = ~last_grant_r;
        end else begin
            grant_wr_s = wr_req;
        end
    end

    // Last winner, reset to read so the first contested grant goes to write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= 1'b0;
        end else if (grant_s) begin
            last_grant_r <= grant_wr_s;
        end
    end
`else
    // Fixed priority winner selection: write beats read
    always_comb begin
        if (wr_req) begin
            grant_wr_s = 1'b1;
        end else begin
            grant_wr_s = 1'b0;
        end
    end
`endif

    // State, phase counter and transaction latches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            addr_r   <= 8'h00;
            data_r   <= 8'h00;
            dir_wr_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (grant_s) begin
                dir_wr_r <= grant_wr_s;
                addr_r   <= grant_wr_s ? wr_addr : rd_addr;
                data_r   <= wr_data;
            end
        end
    end

    // Next-state: each timed state runs until its counter reaches zero, then reloads for the next
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        grant_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (window && (wr_req || rd_req)) begin
                    grant_s = 1'b1;
                    state_s = A_SU;
                    cnt_s   = LD_SETUP;
                end else begin
                    cnt_s = 4'd0;
                end
            end
            A_SU: if (cnt_r == 4'd0) begin state_s = A_PW; cnt_s = LD_PULSE; end
                  else begin cnt_s = cnt_r - 4'd1; end
            A_PW: if (cnt_r == 4'd0) begin state_s = A_HD; cnt_s = LD_HOLD; end
                  else begin cnt_s = cnt_r - 4'd1; end
            A_HD: if (cnt_r == 4'd0) begin state_s = D_SU; cnt_s = LD_SETUP; end
                  else begin cnt_s = cnt_r - 4'd1; end
            D_SU: if (cnt_r == 4'd0) begin state_s = D_PW; cnt_s = LD_PULSE; end
                  else begin cnt_s = cnt_r - 4'd1; end
            D_PW: if (cnt_r == 4'd0) begin state_s = D_HD; cnt_s = LD_HOLD; end
                  else begin cnt_s = cnt_r - 4'd1; end
            D_HD: if (cnt_r == 4'd0) begin state_s = GAP; cnt_s = LD_GAP; end
                  else begin cnt_s = cnt_r - 4'd1; end
            GAP:  if (cnt_r == 4'd0) begin state_s = IDLE; cnt_s = 4'd0; end
                  else begin cnt_s = cnt_r - 4'd1; end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Pin values for the current state; registered below, so pins trail the state by one clock
    always_comb begin
        cs_n_s    = 1'b1;
        ad_n_s    = 1'b1;
        wr_n_s    = 1'b1;
        rd_n_s    = 1'b1;
        ad_oe_s   = 1'b0;
        ad_out_s  = 8'h00;
        wr_ack_s  = 1'b0;
        rd_ack_s  = 1'b0;
        busy_s    = 1'b1;
        capture_s = 1'b0;
        case (state_r)
            IDLE: busy_s = 1'b0;
            A_SU, A_HD: begin
                cs_n_s   = 1'b0;
                ad_n_s   = 1'b0;
                ad_oe_s  = 1'b1;
                ad_out_s = addr_r;
            end
            A_PW: begin
                cs_n_s   = 1'b0;
                ad_n_s   = 1'b0;
                wr_n_s   = 1'b0;
                ad_oe_s  = 1'b1;
                ad_out_s = addr_r;
            end
            D_SU, D_HD: begin
                cs_n_s   = 1'b0;
                ad_oe_s  = dir_wr_r;
                ad_out_s = dir_wr_r ? data_r : 8'h00;
            end
            D_PW: begin
                cs_n_s    = 1'b0;
                wr_n_s    = ~dir_wr_r;
                rd_n_s    = dir_wr_r;
                ad_oe_s   = dir_wr_r;
                ad_out_s  = dir_wr_r ? data_r : 8'h00;
                capture_s = ~dir_wr_r && (cnt_r == 4'd0);
            end
            GAP: begin
                if (cnt_r == LD_GAP) begin
                    wr_ack_s = dir_wr_r;
                    rd_ack_s = ~dir_wr_r;
                end else begin
                    wr_ack_s = 1'b0;
                    rd_ack_s = 1'b0;
                end
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Output registers; reset forces the bus idle immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rtc_cs_n <= 1'b1;
            rtc_ad_n <= 1'b1;
            rtc_wr_n <= 1'b1;
            rtc_rd_n <= 1'b1;
            ad_oe    <= 1'b0;
            ad_out   <= 8'h00;
            wr_ack   <= 1'b0;
            rd_ack   <= 1'b0;
            busy     <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            rtc_cs_n <= cs_n_s;
            rtc_ad_n <= ad_n_s;
            rtc_wr_n <= wr_n_s;
            rtc_rd_n <= rd_n_s;
            ad_oe    <= ad_oe_s;
            ad_out   <= ad_out_s;
            wr_ack   <= wr_ack_s;
            rd_ack   <= rd_ack_s;
            busy     <= busy_s;
            if (capture_s) begin
                rd_data <= ad_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench for rtc_bus_arbiter: stimulus queues expected transactions, a pin-level
// monitor rebuilds each bus cycle and compares it when the ack appears.
module tb_rtc_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, window, wr_req, rd_req;
    logic [7:0] wr_addr, wr_data, rd_addr, ad_in, rd_data, ad_out;
    logic       wr_ack, rd_ack, busy, cs_n, ad_n, wr_n, rd_n, ad_oe;

    logic       window1, wr_req1, rd_req1;
    logic [7:0] wr_addr1, wr_data1, rd_addr1, ad_in1, rd_data1, ad_out1;
    logic       wr_ack1, rd_ack1, busy1, cs_n1, ad_n1, wr_n1, rd_n1, ad_oe1;

    rtc_bus_arbiter dut (
        .clk(clk), .reset(reset), .window(window),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .busy(busy), .rtc_cs_n(cs_n), .rtc_ad_n(ad_n), .rtc_wr_n(wr_n), .rtc_rd_n(rd_n),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    rtc_bus_arbiter #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .window(window1),
        .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_ack(wr_ack1),
        .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_ack(rd_ack1), .rd_data(rd_data1),
        .busy(busy1), .rtc_cs_n(cs_n1), .rtc_ad_n(ad_n1), .rtc_wr_n(wr_n1), .rtc_rd_n(rd_n1),
        .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in1)
    );

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;   // write data, or the value the RTC returns for a read
        int         fall;   // cycle at which cs_n is first seen low
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] last_rd_m = 8'h00;
    bit         last_wr_m = 1'b0;
    logic [7:0] rd_value = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, expv, expv, cyc);
        end
    endtask

    // RTC device model: returns rd_value only while it is being read, otherwise noise
    always @(negedge clk) begin
        if (!cs_n && !rd_n) ad_in = rd_value;
        else ad_in = 8'($urandom);
    end

    // Reference arbitration: which requester should win
    function automatic bit pick_write(input bit w, input bit r);
`ifdef RTC_RR_ARB_EN
        if (w && r) return !last_wr_m;
`endif
        return w;
    endfunction

    int         fall_cyc = -1, low_cnt = 0, a_str = 0, d_wr = 0, d_rd = 0;
    logic [7:0] cap_addr = 8'h00, cap_data = 8'h00;
    logic       prev_cs = 1'b1;
    exp_t       me;

    // Monitor: rebuild the bus cycle from the pins, score it on ack
    always @(negedge clk) begin
        if (!cs_n && prev_cs) begin
            fall_cyc = cyc; low_cnt = 0; a_str = 0; d_wr = 0; d_rd = 0;
            cap_addr = 8'h00; cap_data = 8'h00;
        end
        if (!cs_n) begin
            low_cnt++;
            if (!ad_n) begin
                check("addr_phase_oe", int'(ad_oe), 1);
                if (!wr_n) begin a_str++; cap_addr = ad_out; end
            end else begin
                if (!wr_n) begin d_wr++; cap_data = ad_out; end
                if (!rd_n) d_rd++;
            end
        end
        prev_cs = cs_n;
        check("ack_overlap", int'(wr_ack & rd_ack), 0);
        check("oe_during_rd", int'(ad_oe & ~rd_n), 0);
        if (wr_ack || rd_ack) begin
            check("ack_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                check("ack_dir", int'(wr_ack), int'(me.is_wr));
                check("cs_fall_cycle", fall_cyc, me.fall);
                check("ack_cycle", cyc, me.fall + 16);
                check("cs_low_len", low_cnt, 16);
                check("addr_strobe_len", a_str, 4);
                check("bus_addr", int'(cap_addr), int'(me.addr));
                if (me.is_wr) begin
                    check("wr_strobe_len", d_wr, 4);
                    check("rd_strobe_len", d_rd, 0);
                    check("bus_data", int'(cap_data), int'(me.data));
                end else begin
                    check("rd_strobe_len", d_rd, 4);
                    check("wr_strobe_len", d_wr, 0);
                    last_rd_m = me.data;
                end
                check("rd_data", int'(rd_data), int'(last_rd_m));
            end
        end
    end

    task automatic wait_ack(output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (wr_ack || rd_ack) begin at = cyc; break; end
        end
        check("ack_seen", int'(at >= 0), 1);
    endtask

    task automatic run_txn(input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                           input int win_wait, input bit drop_win, input bit drop_req);
        exp_t e;
        int   k, at;
        if (is_wr) begin wr_addr = a; wr_data = d; wr_req = 1'b1; end
        else begin rd_addr = a; rd_value = d; rd_req = 1'b1; end
        window = (win_wait == 0);
        for (int i = 0; i < win_wait; i++) begin
            @(negedge clk);
            check("closed_busy", int'(busy), 0);
            check("closed_cs_n", int'(cs_n), 1);
        end
        window = 1'b1;
        k = cyc;
        e.is_wr = pick_write(is_wr, !is_wr);
        e.addr = a; e.data = d; e.fall = k + 2;
        exp_q.push_back(e);
        last_wr_m = e.is_wr;
        repeat (4) @(negedge clk);
        wr_addr = 8'($urandom); wr_data = 8'($urandom); rd_addr = 8'($urandom);
        if (drop_req) begin wr_req = 1'b0; rd_req = 1'b0; end
        @(negedge clk);
        if (drop_win) window = 1'b0;
        wait_ack(at);
        wr_req = 1'b0; rd_req = 1'b0; window = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic contention();
        exp_t       e;
        int         k, at;
        logic [7:0] wa, wd, ra, rv;
        wa = 8'($urandom); wd = 8'($urandom); ra = 8'($urandom); rv = 8'($urandom);
        wr_addr = wa; wr_data = wd; rd_addr = ra; rd_value = rv;
        window = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            e.is_wr = pick_write(1'b1, 1'b1);
            e.addr  = e.is_wr ? wa : ra;
            e.data  = e.is_wr ? wd : rv;
            e.fall  = k + 2 + 20 * i;
            exp_q.push_back(e);
            last_wr_m = e.is_wr;
        end
        for (int i = 0; i < 4; i++) wait_ack(at);
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_test();
        exp_t e;
        int   k, at;
        wr_addr = 8'h5A; wr_data = 8'hC6; window = 1'b1; wr_req = 1'b1;
        k = cyc;
        e.is_wr = 1'b1; e.addr = 8'h5A; e.data = 8'hC6; e.fall = k + 2;
        exp_q.push_back(e);
        last_wr_m = 1'b1;
        repeat (13) @(posedge clk);
        #2;
        check("pre_reset_wr_n", int'(wr_n), 0);
        reset = 1'b0;
        #1;
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_wr_n", int'(wr_n), 1);
        check("rst_rd_n", int'(rd_n), 1);
        check("rst_ad_oe", int'(ad_oe), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_busy", int'(busy), 0);
        exp_q.delete();
        last_rd_m = 8'h00; last_wr_m = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        k = cyc;
        e.fall = k + 2;
        exp_q.push_back(e);
        last_wr_m = 1'b1;
        wait_ack(at);
        wr_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic fast_test();
        int k, at;
        wr_addr1 = 8'h3E; wr_data1 = 8'h7B; wr_req1 = 1'b1;
        k = cyc;
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            check("fast_cs_n", int'(cs_n1), int'(!(s >= 2 && s <= 7)));
            check("fast_ad_n", int'(ad_n1), int'(!(s >= 2 && s <= 4)));
            check("fast_wr_n", int'(wr_n1), int'(!(s == 3 || s == 6)));
            check("fast_rd_n", int'(rd_n1), 1);
            check("fast_ad_oe", int'(ad_oe1), int'(s >= 2 && s <= 7));
            check("fast_wr_ack", int'(wr_ack1), int'(s == 8));
            check("fast_rd_ack", int'(rd_ack1), 0);
            check("fast_busy", int'(busy1), int'(s >= 2));
            if (s == 3) check("fast_addr", int'(ad_out1), 8'h3E);
            if (s == 6) check("fast_data", int'(ad_out1), 8'h7B);
        end
        at = -1;
        for (int n = 0; n < 20 && at < 0; n++) begin
            @(negedge clk);
            if (wr_ack1) at = cyc;
        end
        check("fast_second_ack", at, k + 16);
        wr_req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("fast_idle_busy", int'(busy1), 0);
        check("fast_rd_data", int'(rd_data1), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bit         w, dw, dr;
        logic [7:0] a, d;
        int         ww;
        reset = 1'b1; window = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00;
        window1 = 1'b1; wr_req1 = 1'b0; rd_req1 = 1'b0;
        wr_addr1 = 8'h00; wr_data1 = 8'h00; rd_addr1 = 8'h00; ad_in1 = 8'h00;
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_cs_n", int'(cs_n), 1);
        check("reset_ad_n", int'(ad_n), 1);
        check("reset_wr_n", int'(wr_n), 1);
        check("reset_rd_n", int'(rd_n), 1);
        check("reset_ad_oe", int'(ad_oe), 0);
        check("reset_ad_out", int'(ad_out), 0);
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_acks", int'({wr_ack, rd_ack}), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(1'b1, 8'h21, 8'h45, 0, 1'b0, 1'b0);
        run_txn(1'b0, 8'h24, 8'h59, 0, 1'b0, 1'b0);
        run_txn(1'b1, 8'h30, 8'hA5, 0, 1'b0, 1'b0);
        run_txn(1'b0, 8'h26, 8'h3C, 50, 1'b0, 1'b0);
        run_txn(1'b1, 8'h27, 8'h11, 0, 1'b1, 1'b0);
        run_txn(1'b0, 8'h28, 8'hC3, 0, 1'b0, 1'b1);
        contention();
        reset_test();

        for (int it = 0; it < 30; it++) begin
            w  = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            d  = 8'($urandom);
            ww = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_txn(w, a, d, ww, dw, dr);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        fast_test();
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
